// File: rtl/song_memory_bank.sv
// song_memory_bank
//   Multi-song note store for the organ. NUM_SONGS independent slots of DEPTH words each.
//   Notes are appended to the selected slot while the organ is outside the play modes and
//   streamed back one word per read request while in AUTOPLAY, LEARNING or GAME. Each slot
//   tracks its own length; playback can stop at the last word or loop back to word 0.
//
// Ports
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   current_state  in   top-level mode: 0 AUTOPLAY, 1 LEARNING, 2 GAME, others non-play
//   song_sel       in   selected slot for write, clear, read and duration
//   write_en       in   append data_in to the selected slot
//   clear_song     in   empty the selected slot (wins over write_en)
//   data_in        in   note word to record
//   read_en        in   request the next word of the selected slot
//   read_rst       in   restart playback at word 0
//   loop_en        in   wrap to word 0 after the last word instead of stopping
//   data_out       out  registered note word
//   output_ready   out  one-cycle pulse, data_out valid
//   song_end       out  one-cycle pulse alongside output_ready of the last word
//   full           out  selected slot holds DEPTH words
//   duration       out  word count of the selected slot (combinational)

module song_memory_bank #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned NUM_SONGS   = 4,
    parameter int unsigned STATE_WIDTH = 2,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned SW = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [STATE_WIDTH-1:0] current_state,
    input  logic [SW-1:0]          song_sel,
    input  logic                   write_en,
    input  logic                   clear_song,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   read_en,
    input  logic                   read_rst,
    input  logic                   loop_en,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   output_ready,
    output logic                   song_end,
    output logic                   full,
    output logic [AW:0]            duration
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StPlay = 2'b01,
        StDone = 2'b10
    } rd_state_e;

    localparam logic [AW:0] DepthLen = (AW + 1)'(DEPTH);
    localparam logic [AW:0] OneLen   = (AW + 1)'(1);

    // Note storage; deliberately not reset, a slot is only readable below its length.
    logic [DATA_WIDTH-1:0] mem [NUM_SONGS][DEPTH];

    logic [AW:0]   len [NUM_SONGS];
    logic [AW-1:0] rd_ptr;
    logic [SW-1:0] sel_q;
    rd_state_e     rd_state;

    logic          play;
    logic          sel_valid;
    logic [AW:0]   cur_len;
    logic          rrst;
    logic          wr_fire;
    logic          clr_fire;
    logic          rd_fire;
    logic          last_word;

    always_comb begin
        play = (current_state == STATE_WIDTH'(0)) ||
               (current_state == STATE_WIDTH'(1)) ||
               (current_state == STATE_WIDTH'(2));

        // Guards non-power-of-two slot counts, where song_sel can name a missing slot.
        sel_valid = (32'(song_sel) < NUM_SONGS);
        cur_len   = '0;
        if (sel_valid) begin
            cur_len = len[song_sel];
        end

        full     = (cur_len == DepthLen);
        duration = cur_len;

        // Any change of slot, leaving the play modes or an explicit restart rewinds playback.
        rrst = read_rst || !play || (song_sel != sel_q);

        clr_fire  = !play && clear_song && sel_valid;
        wr_fire   = !play && write_en && !clear_song && !full && sel_valid;
        rd_fire   = !rrst && read_en && (rd_state != StDone) && (cur_len != '0);
        last_word = ({1'b0, rd_ptr} == (cur_len - OneLen));
    end

    // Memory write port.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[song_sel][cur_len[AW-1:0]] <= data_in;
        end
    end

    // Per-slot length bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SONGS; s++) begin
                len[s] <= '0;
            end
        end else if (clr_fire) begin
            len[song_sel] <= '0;
        end else if (wr_fire) begin
            len[song_sel] <= cur_len + OneLen;
        end
    end

    // Playback FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state     <= StIdle;
            rd_ptr       <= '0;
            sel_q        <= '0;
            data_out     <= '0;
            output_ready <= 1'b0;
            song_end     <= 1'b0;
        end else begin
            sel_q        <= song_sel;
            output_ready <= 1'b0;
            song_end     <= 1'b0;

            if (!play) begin
                data_out <= '0;
            end

            if (rrst) begin
                rd_ptr   <= '0;
                rd_state <= StIdle;
            end else begin
                case (rd_state)
                    StIdle, StPlay: begin
                        if (rd_fire) begin
                            data_out     <= mem[song_sel][rd_ptr];
                            output_ready <= 1'b1;
                            rd_state     <= StPlay;
                            if (last_word) begin
                                song_end <= 1'b1;
                                rd_ptr   <= '0;
                                if (!loop_en) begin
                                    rd_state <= StDone;
                                end
                            end else begin
                                rd_ptr <= rd_ptr + 1'b1;
                            end
                        end
                    end
                    StDone: begin
                        // Parked until a rewind; further reads produce nothing.
                        rd_state <= StDone;
                    end
                    default: begin
                        rd_state <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_song_memory_bank.sv
module tb_song_memory_bank;

    localparam int DW = 8;
    localparam int AW = 6;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    current_state;
    logic [SW-1:0] song_sel;
    logic          write_en;
    logic          clear_song;
    logic [DW-1:0] data_in;
    logic          read_en;
    logic          read_rst;
    logic          loop_en;
    logic [DW-1:0] data_out;
    logic          output_ready;
    logic          song_end;
    logic          full;
    logic [AW:0]   duration;

    int checks = 0;
    int errors = 0;

    song_memory_bank #(
        .DATA_WIDTH (8),
        .DEPTH      (64),
        .NUM_SONGS  (4),
        .STATE_WIDTH(2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .current_state(current_state),
        .song_sel     (song_sel),
        .write_en     (write_en),
        .clear_song   (clear_song),
        .data_in      (data_in),
        .read_en      (read_en),
        .read_rst     (read_rst),
        .loop_en      (loop_en),
        .data_out     (data_out),
        .output_ready (output_ready),
        .song_end     (song_end),
        .full         (full),
        .duration     (duration)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change right after a falling edge; outputs are sampled at the next falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    // Expect a read result: ready, data and end flag.
    task automatic chk_rd(input string tag, input logic rdy, input logic [7:0] d,
                          input logic e);
        chk({tag, ".rdy"}, 32'(output_ready), 32'(rdy));
        chk({tag, ".data"}, 32'(data_out), 32'(d));
        chk({tag, ".end"}, 32'(song_end), 32'(e));
    endtask

    initial begin
        rst_n         = 1'b0;
        current_state = 2'b11;
        song_sel      = '0;
        write_en      = 1'b0;
        clear_song    = 1'b0;
        data_in       = '0;
        read_en       = 1'b0;
        read_rst      = 1'b0;
        loop_en       = 1'b0;

        // Reset values
        #3;
        chk_rd("reset", 1'b0, 8'h00, 1'b0);
        chk("reset.full", 32'(full), 32'd0);
        chk("reset.dur", 32'(duration), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // 1. Record three notes into slot 1
        song_sel = 2'd1;
        write_en = 1'b1;
        data_in  = 8'h11;
        step();
        data_in  = 8'h22;
        step();
        data_in  = 8'h33;
        step();
        write_en = 1'b0;
        chk("t1.dur", 32'(duration), 32'd3);
        chk("t1.full", 32'(full), 32'd0);
        song_sel = 2'd0;
        #1;
        chk("t1.dur_s0", 32'(duration), 32'd0);
        step();

        // 2. Play slot 1 without loop
        current_state = 2'b00;
        song_sel      = 2'd1;
        step();
        read_en = 1'b1;
        step();
        chk_rd("t2.r1", 1'b1, 8'h11, 1'b0);
        step();
        chk_rd("t2.r2", 1'b1, 8'h22, 1'b0);
        step();
        chk_rd("t2.r3", 1'b1, 8'h33, 1'b1);
        step();
        chk_rd("t2.r4", 1'b0, 8'h33, 1'b0);
        read_en = 1'b0;

        // 3. Restart and play with loop
        read_rst = 1'b1;
        step();
        read_rst = 1'b0;
        loop_en  = 1'b1;
        read_en  = 1'b1;
        step();
        chk_rd("t3.r1", 1'b1, 8'h11, 1'b0);
        step();
        chk_rd("t3.r2", 1'b1, 8'h22, 1'b0);
        step();
        chk_rd("t3.r3", 1'b1, 8'h33, 1'b1);
        step();
        chk_rd("t3.r4", 1'b1, 8'h11, 1'b0);
        read_en = 1'b0;
        loop_en = 1'b0;
        step();
        chk("t3.idle_rdy", 32'(output_ready), 32'd0);
        chk("t3.hold", 32'(data_out), 32'h11);

        // 5a. Mid-play read_rst returns to word 0
        read_rst = 1'b1;
        step();
        read_rst = 1'b0;
        read_en  = 1'b1;
        step();
        chk_rd("t5.rst_r1", 1'b1, 8'h11, 1'b0);
        step();
        chk_rd("t5.rst_r2", 1'b1, 8'h22, 1'b0);
        read_en = 1'b0;

        // 5b. Slot 1 -> 2 -> 1 rewinds playback
        song_sel = 2'd2;
        step();
        song_sel = 2'd1;
        step();
        read_en = 1'b1;
        step();
        chk_rd("t5.sel_r1", 1'b1, 8'h11, 1'b0);
        read_en = 1'b0;
        step();

        // Empty slot: read produces nothing
        song_sel = 2'd3;
        step();
        read_en = 1'b1;
        step();
        chk("empty.rdy", 32'(output_ready), 32'd0);
        read_en = 1'b0;

        // 6. Non-play read, play-mode write
        current_state = 2'b11;
        song_sel      = 2'd1;
        read_en       = 1'b1;
        step();
        chk_rd("t6.np_read", 1'b0, 8'h00, 1'b0);
        read_en       = 1'b0;
        current_state = 2'b10;
        write_en      = 1'b1;
        data_in       = 8'h44;
        step();
        write_en = 1'b0;
        chk("t6.game_wr", 32'(duration), 32'd3);

        // 4. Fill slot 0, overflow, then clear with a simultaneous write
        current_state = 2'b11;
        song_sel      = 2'd0;
        step();
        for (int i = 0; i < 65; i++) begin
            write_en = 1'b1;
            data_in  = 8'(i);
            step();
            if (i == 62) begin
                chk("t4.dur63", 32'(duration), 32'd63);
                chk("t4.full63", 32'(full), 32'd0);
            end
            if (i == 63) begin
                chk("t4.dur64", 32'(duration), 32'd64);
                chk("t4.full64", 32'(full), 32'd1);
            end
        end
        write_en = 1'b0;
        chk("t4.dur65", 32'(duration), 32'd64);
        chk("t4.full65", 32'(full), 32'd1);
        clear_song = 1'b1;
        write_en   = 1'b1;
        data_in    = 8'h55;
        step();
        clear_song = 1'b0;
        write_en   = 1'b0;
        chk("t4.clr_dur", 32'(duration), 32'd0);
        chk("t4.clr_full", 32'(full), 32'd0);
        song_sel = 2'd1;
        #1;
        chk("t4.s1_kept", 32'(duration), 32'd3);
        step();

        // 5c. Asynchronous reset mid-playback
        current_state = 2'b00;
        step();
        read_en = 1'b1;
        step();
        chk_rd("t5.pre_rst", 1'b1, 8'h11, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_rd("t5.async_rst", 1'b0, 8'h00, 1'b0);
        chk("t5.rst_dur", 32'(duration), 32'd0);
        chk("t5.rst_full", 32'(full), 32'd0);
        read_en = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("t5.after_dur", 32'(duration), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
